// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the pipeline request/response handshake and the memory port
// seen by the data-memory access controller. The controller connects through
// the slave modport; the pipeline/memory environment uses the master modport.
interface dmem_access_ctrl_if;
  // Pipeline request
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [2:0]  i_req_size;
  // Pipeline response
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic [2:0]  o_rsp_type;
  logic        o_rsp_err;
  // Memory port
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_type, o_rsp_err,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_type, o_rsp_err,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts one load/store at a time from the
// pipeline, checks alignment/size legality, issues a word-aligned memory
// request with byte-lane steering, extracts load data and reports completion,
// error or timeout as a single-cycle response pulse.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_rst_n,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [2:0]  size_q;
  // One bit wider than the limit so a grant landing exactly on the limit can
  // keep counting through the first wait cycle without wrapping.
  logic [8:0]  cnt_q;
  logic [8:0]  cnt_d;
  logic        limit_hit;

  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [2:0]  rsp_type_q;
  logic        rsp_err_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;

  // Legal size/alignment combinations; stores have no unsigned variants.
  function automatic logic req_legal(input logic we, input logic [2:0] size,
                                     input logic [1:0] off);
    logic ok;
    case (size)
      3'b000:  ok = 1'b1;
      3'b100:  ok = !we;
      3'b001:  ok = !off[0];
      3'b101:  ok = !we && !off[0];
      3'b010:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate the store operand across every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz,
                                             input logic [31:0] wdata);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Byte enables for the addressed lanes of a store.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Shift the addressed bytes of the read word down to bit 0, zero above.
  function automatic logic [31:0] load_align(input logic [1:0] sz, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {off, 3'b000};
    case (sz)
      2'b00:   r = {24'h0, sh[7:0]};
      2'b01:   r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign cnt_d     = cnt_q + 9'd1;
  assign limit_hit = (cnt_d >= 9'(TIMEOUT_CYCLES));

  // Access sequencer: request capture, memory handshake, timeout and response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      size_q      <= 3'b000;
      cnt_q       <= 9'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_type_q  <= 3'b000;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (bus.i_req_valid) begin
            off_q  <= bus.i_req_addr[1:0];
            we_q   <= bus.i_req_we;
            size_q <= bus.i_req_size;
            if (req_legal(bus.i_req_we, bus.i_req_size, bus.i_req_addr[1:0])) begin
              state_q     <= REQ;
              cnt_q       <= 9'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.i_req_we;
              mem_addr_q  <= {bus.i_req_addr[31:2], 2'b00};
              mem_wdata_q <= bus.i_req_we ? lane_wdata(bus.i_req_size[1:0], bus.i_req_wdata)
                                          : 32'h0;
              mem_be_q    <= bus.i_req_we ? lane_be(bus.i_req_size[1:0], bus.i_req_addr[1:0])
                                          : 4'b1111;
            end else begin
              // Illegal requests complete at once and never reach memory.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'h0;
              rsp_type_q  <= bus.i_req_size;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_d;
          // A grant on the limit cycle still counts as success.
          if (bus.i_mem_gnt) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= 32'h0;
              rsp_type_q  <= size_q;
            end else begin
              state_q <= WAIT;
            end
          end else if (limit_hit) begin
            mem_req_q   <= 1'b0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 32'h0;
            rsp_type_q  <= size_q;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (bus.i_mem_rvalid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= load_align(size_q[1:0], off_q, bus.i_mem_rdata);
            rsp_type_q  <= size_q;
          end else if (limit_hit) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 32'h0;
            rsp_type_q  <= size_q;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_type  = rsp_type_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_be    = mem_be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] obs_addr, obs_wdata, obs_rsp_data;
  logic [3:0]  obs_be;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. g = cycle of the grant pulse (counting the accept cycle
  // as 0); r = number of wait cycles until read data (1 = cycle after grant).
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int g, input int r, input bit busy, input bit noise);
    int nb, off, exp_cyc, req_end, j_to;
    bit legal, tmo;
    logic [31:0] e_wd, e_data;
    logic [3:0]  e_be;
    int waited;

    // Reference model
    nb = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : (size[1:0] == 2'd2) ? 4 : 0;
    off = int'(addr[1:0]);
    legal = (nb != 0) && !(size[2] && nb == 4) && !(we && size[2]) && ((addr % nb) == 0);
    e_wd = 32'h0; e_be = 4'h0; e_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      e_be[i] = we ? (i >= off && i < off + nb) : 1'b1;
      if (we && nb != 0) e_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
    for (int i = 0; i < 4; i++)
      if (i < nb && off + i < 4) e_data[8*i +: 8] = rdata[8*(off + i) +: 8];
    tmo = 1'b0;
    if (!legal) begin
      exp_cyc = 1; req_end = 0; tmo = 1'b1;
    end else if (g > T) begin
      exp_cyc = T + 1; req_end = T; tmo = 1'b1;
    end else if (we) begin
      exp_cyc = g + 1; req_end = g;
    end else begin
      req_end = g;
      j_to = (T - g > 1) ? T - g : 1;
      if (r <= j_to) exp_cyc = g + r + 1;
      else begin exp_cyc = g + j_to + 1; tmo = 1'b1; end
    end
    if (we || tmo) e_data = 32'h0;

    waited = 0;
    while (bus.o_req_ready !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    chk("ready_before_req", {31'h0, bus.o_req_ready}, 32'h1);

    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_size  = size;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wdata;
    bus.i_mem_rdata = rdata;
    step();
    bus.i_req_valid = 1'b0;

    for (int cyc = 1; cyc <= exp_cyc; cyc++) begin
      bus.i_mem_gnt    = legal && (g <= T) && (cyc == g);
      bus.i_mem_rvalid = (legal && !we && (g <= T) && (cyc == g + r)) || (noise && cyc <= g);
      if (busy && cyc < exp_cyc) begin
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = 1'($urandom);
        bus.i_req_size  = 3'($urandom);
        bus.i_req_addr  = $urandom;
        bus.i_req_wdata = $urandom;
      end else begin
        bus.i_req_valid = 1'b0;
      end
      chk("ready_busy", {31'h0, bus.o_req_ready}, 32'h0);
      chk("rsp_valid", {31'h0, bus.o_rsp_valid}, {31'h0, cyc == exp_cyc});
      chk("mem_req", {31'h0, bus.o_mem_req}, {31'h0, legal && cyc <= req_end});
      if (legal) begin
        chk("mem_addr", bus.o_mem_addr, {addr[31:2], 2'b00});
        chk("mem_we", {31'h0, bus.o_mem_we}, {31'h0, we});
        chk("mem_be", {28'h0, bus.o_mem_be}, {28'h0, e_be});
        chk("mem_wdata", bus.o_mem_wdata, e_wd);
      end
      if (cyc == 1) begin
        obs_addr = bus.o_mem_addr; obs_wdata = bus.o_mem_wdata; obs_be = bus.o_mem_be;
      end
      if (cyc == exp_cyc) begin
        obs_rsp_data = bus.o_rsp_data;
        chk("rsp_data", bus.o_rsp_data, e_data);
        chk("rsp_err", {31'h0, bus.o_rsp_err}, {31'h0, tmo});
        chk("rsp_type", {29'h0, bus.o_rsp_type}, {29'h0, size});
      end
      step();
    end
    bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_req_valid = 1'b0;
    chk("rsp_pulse_end", {31'h0, bus.o_rsp_valid}, 32'h0);
    chk("ready_after", {31'h0, bus.o_req_ready}, 32'h1);
    chk("rsp_data_hold", bus.o_rsp_data, e_data);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, bus.o_req_ready}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, bus.o_rsp_valid}, 32'h0);
    chk({tag, "_rsp_data"}, bus.o_rsp_data, 32'h0);
    chk({tag, "_rsp_type"}, {29'h0, bus.o_rsp_type}, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, bus.o_rsp_err}, 32'h0);
    chk({tag, "_mem_req"}, {31'h0, bus.o_mem_req}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, bus.o_mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, bus.o_mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 32'h0);
    chk({tag, "_mem_be"}, {28'h0, bus.o_mem_be}, 32'h0);
  endtask

  initial begin
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;
    bus.i_req_size   = 3'b000;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'h0;

    // Reset values
    step(); step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // LBU 0x103
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'hAABBCCDD, 1, 1, 1'b0, 1'b1);
    chk("lbu_addr", obs_addr, 32'h100);
    chk("lbu_data", obs_rsp_data, 32'h000000AA);

    // SH 0x22
    run_txn(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 1, 1, 1'b0, 1'b0);
    chk("sh_addr", obs_addr, 32'h20);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_be", {28'h0, obs_be}, 32'hC);

    // Misaligned LW / LH
    run_txn(1'b0, 3'b010, 32'h41, 32'h0, 32'h11223344, 1, 1, 1'b0, 1'b0);
    run_txn(1'b0, 3'b001, 32'h43, 32'h0, 32'h11223344, 1, 1, 1'b0, 1'b0);

    // Timeout with no grant, then grant on the limit cycle and data next
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEADBEEF, 100, 1, 1'b0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'hDEADBEEF, T, 1, 1'b0, 1'b0);

    // Delayed grant with a second request held pending throughout
    run_txn(1'b0, 3'b101, 32'h1C6, 32'h0, 32'h8765CAFE, 4, 1, 1'b1, 1'b0);

    // Reset during WAIT, then a stale read-data pulse
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_size = 3'b010;
    bus.i_req_addr = 32'h300; bus.i_mem_rdata = 32'h55AA55AA;
    step();
    bus.i_req_valid = 1'b0;
    bus.i_mem_gnt = 1'b1;
    step();
    bus.i_mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    step();
    bus.i_mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stale_rvalid", {31'h0, bus.o_rsp_valid}, 32'h0);
      step();
    end
    run_txn(1'b1, 3'b000, 32'h5, 32'h000000C3, 32'h0, 1, 1, 1'b0, 1'b0);
    chk("sb_be", {28'h0, obs_be}, 32'h2);

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
              ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 1..255: maximum cycles to wait for memory grant plus read data before aborting the access.
REQ-002 i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 i_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 i_req_valid, input, 1: pipeline presents a load/store request.
REQ-005 o_req_ready, output, 1: block accepts a request; a transfer occurs when i_req_valid and o_req_ready are both high.
REQ-006 i_req_we, input, 1: 1 = store, 0 = load.
REQ-007 i_req_addr, input, 32: byte address.
REQ-008 i_req_wdata, input, 32: store data, right-justified.
REQ-009 i_req_size, input, 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 o_rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 o_rsp_data, output, 32: load data shifted to bits [7:0]/[15:0]/[31:0], ready for sign/zero extension by the load unit; 0 for stores and errors.
REQ-012 o_rsp_type, output, 3: registered i_req_size of the completed request.
REQ-013 o_rsp_err, output, 1: completion is misaligned, illegal-size or timeout.
REQ-014 o_mem_req, output, 1: memory request, held until granted.
REQ-015 o_mem_we / o_mem_addr / o_mem_wdata / o_mem_be, output, 1/32/32/4: write enable, word-aligned address ({addr[31:2],2'b00}), lane-replicated data and byte enables.
REQ-016 i_mem_gnt / i_mem_rvalid / i_mem_rdata, input, 1/1/32: grant, read-data valid and read word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT and RESP; o_req_ready = 1 only in IDLE.
REQ-018 On a transfer in IDLE, addr, we, size and wdata SHALL be registered and the state SHALL go to REQ, or to RESP with err=1 when the request is illegal.
REQ-019 A request is illegal when: H/HU with addr[0]=1; W with addr[1:0]!=0; load size 011/110/111; store size other than 000/001/010. Illegal requests never assert o_mem_req.
REQ-020 In REQ, o_mem_req=1. On i_mem_gnt, a store goes to RESP and a load goes to WAIT.
REQ-021 In WAIT, on i_mem_rvalid the block SHALL capture i_mem_rdata >> (8*addr[1:0]) with upper bits zeroed per size (B: 24 zeros; H: 16 zeros; W: none) and go to RESP.
REQ-022 i_mem_rvalid outside WAIT, including in the grant cycle, SHALL be ignored.
REQ-023 Store lanes: B gives wdata = {4{wdata[7:0]}} and be = 4'b0001 << addr[1:0]. H gives wdata = {2{wdata[15:0]}} and be = 4'b0011 << (2*addr[1]). W gives wdata unchanged and be = 4'b1111.
REQ-024 For loads, o_mem_be SHALL be 4'b1111 and o_mem_wdata SHALL be 0.
REQ-025 A timeout counter SHALL clear on entering REQ, increment each cycle in REQ or WAIT, and not reset between them.
REQ-026 When the counter reaches TIMEOUT_CYCLES without completion, the state SHALL go to RESP with err=1 and data=0.
REQ-027 If gnt (in REQ) or rvalid (in WAIT) arrives in the same cycle the counter reaches the limit, completion wins and err=0.
REQ-028 RESP SHALL assert o_rsp_valid for exactly one cycle, then return to IDLE; outputs other than o_rsp_valid hold until the next completion.
REQ-029 Minimum load latency: accept at cycle 0, o_mem_req at cycle 1 with gnt, rvalid at cycle 2, o_rsp_valid at cycle 3. Minimum store latency: o_rsp_valid at cycle 2. Illegal request: o_rsp_valid at cycle 1.
REQ-030 Memory-side outputs SHALL be driven from registered state only.

Reset
REQ-031 While i_rst_n=0, the state SHALL be IDLE and o_rsp_valid, o_rsp_data, o_rsp_type, o_rsp_err, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be and the counter SHALL all be 0; o_req_ready SHALL be 1.
REQ-032 Reset asserted mid-access SHALL abort it immediately, with no o_rsp_valid pulse; a later gnt or rvalid for the aborted access SHALL be ignored.

Verification
REQ-033 LBU at addr 0x103, rdata 0xAABBCCDD, gnt at cycle 1, rvalid at cycle 2 -> o_mem_addr 0x100, o_rsp_data 0x000000AA, o_rsp_type 100, err 0, o_rsp_valid at cycle 3.
REQ-034 SH at addr 0x22, wdata 0x1234ABCD -> o_mem_addr 0x20, o_mem_wdata 0xABCDABCD, o_mem_be 1100, o_rsp_valid 1 cycle after gnt.
REQ-035 LW at addr 0x41 -> no o_mem_req, o_rsp_valid and o_rsp_err at cycle 1, data 0; LH at 0x43 -> same result.
REQ-036 TIMEOUT_CYCLES=4, load with gnt never asserted -> o_rsp_err=1 after 4 REQ cycles. Repeat with gnt on the 4th cycle and rvalid next -> err=0.
REQ-037 Gnt delayed 3 cycles -> o_mem_req held stable with a constant address; o_req_ready=0 throughout, and a second i_req_valid is not accepted until IDLE.
REQ-038 i_rst_n pulled low in WAIT, then released, then rvalid -> no o_rsp_valid; a new SB at addr 0x5 afterwards gives be 0010.
